hub75_capture: RTL

- HUB75 receiver: the panel-side end of the link driven by our display path.
- Oversamples sclk/lat/oe/r0..b1/row_select on the system clock and stores each shifted column into a ping-pong line buffer write port.
- Emits per-latch line reports: row, column count, on-time and error flags.
- Used for loopback self-test on hardware and as the scoreboard front-end in display-path benches.

---
 rtl/hub75_pkg.sv | 45 ++++
 rtl/hub75_sync_edge.sv | 40 ++++
 rtl/hub75_capture.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 capture front-end.
package hub75_pkg;

  // Bit positions of each colour line inside o_cap_data = {r0,g0,b0,r1,g1,b1}.
  localparam int CAP_R0 = 5;
  localparam int CAP_G0 = 4;
  localparam int CAP_B0 = 3;
  localparam int CAP_R1 = 2;
  localparam int CAP_G1 = 1;
  localparam int CAP_B1 = 0;
  localparam int CAP_W  = 6;

  // Sticky error vector layout.
  localparam int ERR_SHORT   = 0;
  localparam int ERR_OVF     = 1;
  localparam int ERR_UNBLANK = 2;
  localparam int ERR_W       = 3;

  localparam int ROW_W  = 5;
  localparam int COL_W  = 8;
  localparam int FRM_W  = 16;

  // Per-latch line report (on-time is parameter-sized and kept separately).
  typedef struct packed {
    logic             bank;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] cols;
  } line_rpt_t;

  // Shifted columns per line across the whole chain.
  function automatic int cols_of(int width, int chained);
    return width * chained;
  endfunction

  // Scanned rows: two halves are driven in parallel.
  function automatic int rows_of(int height);
    return height / 2;
  endfunction

  // Column counter increment that sticks at all-ones.
  function automatic logic [COL_W-1:0] col_inc(logic [COL_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/hub75_sync_edge.sv
// N-bit two-flop synchroniser with optional third stage for rising-edge detect.
module hub75_sync_edge #(
  parameter int N    = 1,
  parameter bit EDGE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic [N-1:0] rise
);

  logic [N-1:0] s1, s2;

  // Metastability chain; q is the settled value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

  if (EDGE) begin : g_edge
    logic [N-1:0] s3;
    // Delayed copy of the settled value for edge detection.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) s3 <= '0;
      else     s3 <= s2;
    end
    assign rise = s2 & ~s3;
  end else begin : g_no_edge
    assign rise = '0;
  end

endmodule

// File: rtl/hub75_capture.sv
// HUB75 receiver: oversamples the link, writes shifted columns into a
// ping-pong line buffer and reports each latched line.
module hub75_capture
  import hub75_pkg::*;
#(
  parameter int WIDTH   = 96,
  parameter int HEIGHT  = 48,
  parameter int CHAINED = 1,
  parameter int ON_W    = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            sclk,
  input  logic            lat,
  input  logic            oe,
  input  logic            r0,
  input  logic            g0,
  input  logic            b0,
  input  logic            r1,
  input  logic            g1,
  input  logic            b1,
  input  logic [4:0]      row_select,
  input  logic            clr_err,
  output logic            o_cap_we,
  output logic [7:0]      o_cap_addr,
  output logic [5:0]      o_cap_data,
  output logic            o_line_done,
  output logic            o_line_bank,
  output logic [4:0]      o_line_row,
  output logic [7:0]      o_line_cols,
  output logic [ON_W-1:0] o_line_on,
  output logic [15:0]     o_frame_cnt,
  output logic            o_err_short,
  output logic            o_err_ovf,
  output logic            o_err_unblank
);

  localparam int COLS = cols_of(WIDTH, CHAINED);
  localparam int ROWS = rows_of(HEIGHT);
  localparam logic [COL_W-1:0] COLS8 = COL_W'(COLS);

  // The address map holds 7 column bits and row_select is 5 bits wide.
  if (COLS > 128 || ROWS > 32) begin : g_bad_cfg
    $error("hub75_capture: panel geometry exceeds address fields");
  end

  // ---- input synchronisers ----
  logic [1:0]  ctl_q_unused, ctl_rise;
  logic [CAP_W-1:0] pix_raw;
  logic [11:0] dat_raw, dat_q, dat_rise_unused;

  // Pack colour lines into capture bit order.
  always_comb begin
    pix_raw         = '0;
    pix_raw[CAP_R0] = r0;
    pix_raw[CAP_G0] = g0;
    pix_raw[CAP_B0] = b0;
    pix_raw[CAP_R1] = r1;
    pix_raw[CAP_G1] = g1;
    pix_raw[CAP_B1] = b1;
  end

  assign dat_raw = {oe, row_select, pix_raw};

  hub75_sync_edge #(.N(2), .EDGE(1'b1)) u_sync_ctl (
    .clk  (i_clk),
    .rst  (i_rst),
    .d    ({sclk, lat}),
    .q    (ctl_q_unused),
    .rise (ctl_rise)
  );

  hub75_sync_edge #(.N(12), .EDGE(1'b0)) u_sync_dat (
    .clk  (i_clk),
    .rst  (i_rst),
    .d    (dat_raw),
    .q    (dat_q),
    .rise (dat_rise_unused)
  );

  logic             sclk_rise, lat_rise, oe_s;
  logic [ROW_W-1:0] row_s;
  logic [CAP_W-1:0] pix_s;

  assign sclk_rise = ctl_rise[1];
  assign lat_rise  = ctl_rise[0];
  assign oe_s      = dat_q[11];
  assign row_s     = dat_q[10:6];
  assign pix_s     = dat_q[5:0];

  // ---- line state ----
  logic             bank;
  logic [COL_W-1:0] cnt, cnt_eff;
  logic [ON_W-1:0]  on_cnt;
  logic [ROW_W-1:0] prev_row;
  logic [ERR_W-1:0] err, err_set;
  line_rpt_t        rpt;

  // A column shifted in the latch cycle still belongs to the closing line.
  assign cnt_eff = sclk_rise ? col_inc(cnt) : cnt;

  // Error set conditions for this cycle.
  always_comb begin
    err_set              = '0;
    err_set[ERR_OVF]     = sclk_rise && (cnt >= COLS8);
    err_set[ERR_SHORT]   = lat_rise && (cnt_eff < COLS8);
    err_set[ERR_UNBLANK] = lat_rise && !oe_s;
  end

  // Capture writes, line bookkeeping, reports and sticky errors.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cap_we    <= 1'b0;
      o_cap_addr  <= '0;
      o_cap_data  <= '0;
      o_line_done <= 1'b0;
      o_line_on   <= '0;
      o_frame_cnt <= '0;
      rpt         <= '0;
      bank        <= 1'b0;
      cnt         <= '0;
      on_cnt      <= '0;
      prev_row    <= '0;
      err         <= '0;
    end else begin
      o_cap_we    <= 1'b0;
      o_line_done <= 1'b0;
      err         <= err_set | (err & ~{ERR_W{clr_err}});

      if (sclk_rise && cnt < COLS8) begin
        o_cap_we   <= 1'b1;
        o_cap_addr <= {bank, cnt[6:0]};
        o_cap_data <= pix_s;
      end

      if (lat_rise) begin
        o_line_done <= 1'b1;
        rpt.bank    <= bank;
        rpt.row     <= row_s;
        rpt.cols    <= cnt_eff;
        o_line_on   <= on_cnt;
        if (row_s == '0 && prev_row != '0)
          o_frame_cnt <= o_frame_cnt + 16'd1;
        prev_row    <= row_s;
        bank        <= ~bank;
        cnt         <= '0;
        on_cnt      <= '0;
      end else begin
        cnt <= cnt_eff;
        if (!oe_s && on_cnt != '1)
          on_cnt <= on_cnt + 1'b1;
      end
    end
  end

  assign o_line_bank   = rpt.bank;
  assign o_line_row    = rpt.row;
  assign o_line_cols   = rpt.cols;
  assign o_err_short   = err[ERR_SHORT];
  assign o_err_ovf     = err[ERR_OVF];
  assign o_err_unblank = err[ERR_UNBLANK];

endmodule
